ascii_line_buffer: RTL and testbench
====================================

ASCII_LINE_BUFFER -- requirements
Module: ascii_line_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, maximum characters per line; power of two, >= 4.
REQ-002 SHALL have parameter LW, default $clog2(DEPTH)+1, width of line_len.
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ascii_ready  input  1  character-available level from the scan-code-to-ASCII stage.
REQ-006 SHALL have port ascii  input  7  ASCII code, valid while ascii_ready high.
REQ-007 SHALL have port line_valid  output  1  committed line held and draining.
REQ-008 SHALL have port line_len  output  LW  character count of the current line, 0..DEPTH.
REQ-009 SHALL have port rd_valid  output  1  rd_char valid for consumer.
REQ-010 SHALL have port rd_ready  input  1  consumer accepts rd_char.
REQ-011 SHALL have port rd_char  output  7  current drained character.
REQ-012 SHALL have port rd_last  output  1  rd_char is final character of line.
REQ-013 SHALL have port overflow  output  1  sticky: a character was dropped.

Function
REQ-014 SHALL accept a character only in the cycle where ascii_ready is 1 and its registered previous value is 0 (rising-edge detect); a held-high ascii_ready yields exactly one accept.
REQ-015 SHALL implement states EDIT and DRAIN.
REQ-016 In EDIT, accepted 0x20..0x7E SHALL write buf[line_len] and increment line_len next cycle when line_len < DEPTH; at line_len == DEPTH the character SHALL be dropped and overflow set.
REQ-017 In EDIT, accepted 0x08 (backspace) SHALL decrement line_len when > 0; at 0 no change, no overflow.
REQ-018 In EDIT, accepted 0x0D (enter) with line_len > 0 SHALL transition to DRAIN next cycle, rd_ptr = 0; with line_len == 0 it SHALL be ignored.
REQ-019 In EDIT, all other codes (0x00..0x1F except 0x08/0x0D, 0x7F) SHALL be ignored.
REQ-020 In DRAIN, line_valid and rd_valid SHALL be 1; rd_char = buf[rd_ptr]; rd_last = (rd_ptr == line_len-1).
REQ-021 rd_char/rd_last SHALL hold stable while rd_valid && !rd_ready.
REQ-022 On rd_valid && rd_ready, rd_ptr SHALL increment; if rd_last, next cycle SHALL be EDIT with line_len = 0, rd_ptr = 0.
REQ-023 Characters accepted during DRAIN SHALL be dropped and set overflow; line content unaffected.
REQ-024 In EDIT, line_valid, rd_valid, rd_last SHALL be 0; rd_char SHALL be 0.
REQ-025 Throughput: one accepted character per cycle maximum; one drained character per cycle with rd_ready held high.

Reset
REQ-026 Reset SHALL force state EDIT, line_len 0, rd_ptr 0, overflow 0, edge-detect register 0, all outputs 0; buffer contents need not clear.
REQ-027 Reset mid-DRAIN SHALL abandon the line; the edge-detect register at 0 means an ascii_ready high at reset release counts as a new edge.
REQ-028 overflow SHALL clear only on reset.

Configuration
REQ-029 Macro ASCII_LINE_BUFFER_ECHO_EN, when defined, SHALL add outputs echo_valid (1) and echo_char (7): one-cycle pulse, one cycle after any EDIT-accepted printable (stored) or effective backspace, carrying that code, for on-screen echo.
REQ-030 Without ASCII_LINE_BUFFER_ECHO_EN those ports SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package line_buf_pkg SHALL hold ASCII_BS (7'h08), ASCII_CR (7'h0D), ASCII_PRINT_MIN (7'h20), ASCII_PRINT_MAX (7'h7E), and the EDIT/DRAIN state type.
REQ-032 Rising-edge detection SHALL be sub-module strobe_rise (clock, reset, in, pulse).

Verification
REQ-033 Type "HI" (0x48, 0x49), 0x0D; rd_ready=1 -> line_len=2, rd_char 0x48 then 0x49 with rd_last on 2nd, EDIT next cycle.
REQ-034 Type 'A','B', 0x08, 'C', 0x0D -> drain 0x41, 0x43; 0x08 at line_len 0 -> line_len stays 0.
REQ-035 DEPTH=32: 33 printables then 0x0D -> line_len=32, overflow=1, drains 32 characters.
REQ-036 ascii_ready held high 10 cycles with 'Z' -> exactly one character stored.
REQ-037 In DRAIN with rd_ready=0 for 5 cycles, send 'Q' -> rd_char stable, overflow=1, 'Q' not stored; reset mid-DRAIN -> line_valid=0, line_len=0 next cycle.
REQ-038 With ASCII_LINE_BUFFER_ECHO_EN: 'K' -> echo_valid pulse 1 cycle, echo_char 0x4B; 0x0D produces no echo.

Source files
------------

// File: rtl/line_buf_pkg.sv
// line_buf_pkg -- shared constants and state encoding for ascii_line_buffer.
//   ASCII_*        : control / printable-range codes the line editor reacts to
//   state_t        : EDIT/DRAIN state encoding (ST_EDIT, ST_DRAIN)
//   is_printable() : 0x20..0x7E range test
package line_buf_pkg;

  localparam logic [6:0] ASCII_BS        = 7'h08;
  localparam logic [6:0] ASCII_CR        = 7'h0D;
  localparam logic [6:0] ASCII_PRINT_MIN = 7'h20;
  localparam logic [6:0] ASCII_PRINT_MAX = 7'h7E;

  typedef logic [0:0] state_t;
  localparam state_t ST_EDIT  = 1'b0;
  localparam state_t ST_DRAIN = 1'b1;

  function automatic logic is_printable(input logic [6:0] c);
    return (c >= ASCII_PRINT_MIN) && (c <= ASCII_PRINT_MAX);
  endfunction

endpackage

// File: rtl/strobe_rise.sv
// strobe_rise -- rising-edge detector for a level input.
//   clock : sole clock
//   reset : synchronous, active-high; clears the history bit to 0 so a
//           level already high at reset release counts as a fresh edge
//   in    : level input
//   pulse : high for the cycle where in is 1 and its previous value was 0
module strobe_rise (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clock) begin
    if (reset) prev <= 1'b0;
    else       prev <= in;
  end

  assign pulse = in & ~prev;

endmodule

// File: rtl/ascii_line_buffer.sv
// ascii_line_buffer -- single-line editor for a keyboard ASCII stream.
// Printable characters are appended, backspace deletes, enter commits the
// line, which is then drained one character per handshake.
//
// State table:
//   state    | meaning
//   ST_EDIT  | collecting characters into the line buffer
//   ST_DRAIN | committed line presented on rd_* until rd_last is taken
//
// Ports:
//   clock, reset          : sole clock, synchronous active-high reset
//   ascii_ready, ascii    : character-available level and its code
//   line_valid, line_len  : committed line held / current character count
//   rd_valid, rd_ready    : drain handshake
//   rd_char, rd_last      : drained character and end-of-line marker
//   overflow              : sticky, a character was dropped (reset clears)
//   echo_valid, echo_char : only with ASCII_LINE_BUFFER_ECHO_EN; one-cycle
//                           echo of each stored printable / effective backspace
module ascii_line_buffer
  import line_buf_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ascii_ready,
  input  logic [6:0]    ascii,
  output logic          line_valid,
  output logic [LW-1:0] line_len,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [6:0]    rd_char,
  output logic          rd_last,
  output logic          overflow
`ifdef ASCII_LINE_BUFFER_ECHO_EN
  ,
  output logic          echo_valid,
  output logic [6:0]    echo_char
`endif
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  state_t        state;
  logic [LW-1:0] len_q;
  logic [AW-1:0] rd_ptr;
  logic          overflow_q;
  logic [6:0]    line_mem [DEPTH];

  logic accept;
  logic in_edit;
  logic is_print;
  logic do_store;
  logic do_bs;
  logic do_enter;
  logic do_drop;
  logic last_w;

  strobe_rise u_rise (
    .clock (clock),
    .reset (reset),
    .in    (ascii_ready),
    .pulse (accept)
  );

  assign in_edit  = (state == ST_EDIT);
  assign is_print = is_printable(ascii);
  assign do_store = accept && in_edit && is_print && (len_q != FULL);
  assign do_bs    = accept && in_edit && (ascii == ASCII_BS) && (len_q != '0);
  assign do_enter = accept && in_edit && (ascii == ASCII_CR) && (len_q != '0);
  // Any accept while draining is lost, as is a printable into a full line.
  assign do_drop  = accept && (!in_edit || (is_print && (len_q == FULL)));
  assign last_w   = !in_edit && (LW'(rd_ptr) == (len_q - LW'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_EDIT;
      len_q      <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_drop) overflow_q <= 1'b1;
      case (state)
        ST_EDIT: begin
          if (do_store)      len_q <= len_q + LW'(1);
          else if (do_bs)    len_q <= len_q - LW'(1);
          else if (do_enter) begin
            state  <= ST_DRAIN;
            rd_ptr <= '0;
          end
        end
        default: begin
          if (rd_ready) begin
            if (last_w) begin
              state  <= ST_EDIT;
              len_q  <= '0;
              rd_ptr <= '0;
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
            end
          end
        end
      endcase
    end
  end

  // Buffer contents are not reset; len_q alone defines what is valid.
  always_ff @(posedge clock) begin
    if (do_store) line_mem[len_q[AW-1:0]] <= ascii;
  end

  assign line_valid = !in_edit;
  assign rd_valid   = !in_edit;
  assign rd_char    = in_edit ? 7'h00 : line_mem[rd_ptr];
  assign rd_last    = last_w;
  assign line_len   = len_q;
  assign overflow   = overflow_q;

`ifdef ASCII_LINE_BUFFER_ECHO_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      echo_valid <= 1'b0;
      echo_char  <= 7'h00;
    end else begin
      echo_valid <= do_store || do_bs;
      echo_char  <= (do_store || do_bs) ? ascii : 7'h00;
    end
  end
`else
  // No echo path in this build.
`endif

endmodule

// File: tb/tb_ascii_line_buffer.sv
module tb_ascii_line_buffer;
  import line_buf_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       ascii_ready;
  logic [6:0] ascii;
  logic       line_valid;
  logic [5:0] line_len;
  logic       rd_valid;
  logic       rd_ready;
  logic [6:0] rd_char;
  logic       rd_last;
  logic       overflow;
`ifdef ASCII_LINE_BUFFER_ECHO_EN
  logic       echo_valid;
  logic [6:0] echo_char;
`endif

  ascii_line_buffer #(.DEPTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .ascii_ready (ascii_ready),
    .ascii       (ascii),
    .line_valid  (line_valid),
    .line_len    (line_len),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_char     (rd_char),
    .rd_last     (rd_last),
    .overflow    (overflow)
`ifdef ASCII_LINE_BUFFER_ECHO_EN
    ,
    .echo_valid  (echo_valid),
    .echo_char   (echo_char)
`endif
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] exp_q [$];   // {last, char}
  logic last_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: pops on every drain handshake.
  initial begin
    forever begin
      @(negedge clock);
      if (last_seen) begin
        check("post_last_line_valid", 32'(line_valid), 32'd0);
        check("post_last_line_len", 32'(line_len), 32'd0);
        last_seen = 1'b0;
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_char: got 0x%0h with no expected entry", {rd_last, rd_char});
        end else begin
          check("drain_char", 32'({rd_last, rd_char}), 32'(exp_q.pop_front()));
          if (rd_last) last_seen = 1'b1;
        end
      end
    end
  end

  task automatic send_char(input logic [6:0] c);
    @(posedge clock); #1;
    ascii = c; ascii_ready = 1'b1;
    @(posedge clock); #1;
    ascii_ready = 1'b0;
  endtask

  task automatic push_line(input logic [6:0] c, input logic last);
    exp_q.push_back({last, c});
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!line_valid && exp_q.size() == 0) begin done = 1; break; end
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s: drain not finished, %0d entries left", name, exp_q.size());
    end
  endtask

  task automatic wait_rd_valid(input string name);
    bit done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rd_valid) begin done = 1; break; end
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s: rd_valid never rose, got 0 expected 1", name);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ascii_ready = 1'b0; ascii = 7'h00; rd_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_line_len", 32'(line_len), 32'd0);
    check("rst_line_valid", 32'(line_valid), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_char", 32'(rd_char), 32'd0);
    check("rst_rd_last", 32'(rd_last), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // "HI" + enter
    rd_ready = 1'b1;
    send_char(7'h48);
    send_char(7'h49);
    check("hi_len", 32'(line_len), 32'd2);
    push_line(7'h48, 1'b0);
    push_line(7'h49, 1'b1);
    send_char(ASCII_CR);
    wait_idle("hi_drain");

    // backspace editing and ignored codes
    send_char(7'h41);
    send_char(7'h42);
    send_char(ASCII_BS);
    send_char(7'h43);
    send_char(7'h07);
    send_char(7'h7F);
    check("edit_len", 32'(line_len), 32'd2);
    push_line(7'h41, 1'b0);
    push_line(7'h43, 1'b1);
    send_char(ASCII_CR);
    wait_idle("edit_drain");

    // backspace and enter on an empty line do nothing
    send_char(ASCII_BS);
    check("bs_empty_len", 32'(line_len), 32'd0);
    send_char(ASCII_CR);
    @(negedge clock);
    check("cr_empty_line_valid", 32'(line_valid), 32'd0);
    check("bs_empty_overflow", 32'(overflow), 32'd0);

    // 33 printables into a 32-deep line
    for (int i = 0; i < 33; i++) begin
      logic [6:0] c;
      c = 7'(8'h21 + i);
      send_char(c);
      if (i < 32) push_line(c, (i == 31));
    end
    check("full_len", 32'(line_len), 32'd32);
    check("full_overflow", 32'(overflow), 32'd1);
    send_char(ASCII_CR);
    wait_idle("full_drain");
    check("overflow_sticky", 32'(overflow), 32'd1);
    pulse_reset();
    @(negedge clock);
    check("overflow_cleared", 32'(overflow), 32'd0);

    // held ascii_ready gives a single accept
    @(posedge clock); #1;
    ascii = 7'h5A; ascii_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1 ascii_ready = 1'b0;
    check("held_len", 32'(line_len), 32'd1);
    push_line(7'h5A, 1'b1);
    send_char(ASCII_CR);
    wait_idle("held_drain");

    // stalled drain, character sent during DRAIN is dropped
    rd_ready = 1'b0;
    send_char(7'h50);
    send_char(7'h52);
    send_char(ASCII_CR);
    wait_rd_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin ascii = 7'h51; ascii_ready = 1'b1; end
      if (i == 3) ascii_ready = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      check("stall_rd_char", 32'({rd_valid, rd_last, rd_char}), 32'({1'b1, 1'b0, 7'h50}));
    end
    check("stall_overflow", 32'(overflow), 32'd1);
    check("stall_len", 32'(line_len), 32'd2);
    push_line(7'h50, 1'b0);
    push_line(7'h52, 1'b1);
    @(posedge clock); #1 rd_ready = 1'b1;
    wait_idle("stall_drain");

    // reset mid-DRAIN abandons the line; ascii_ready high at release is a new edge
    rd_ready = 1'b0;
    send_char(7'h58);
    send_char(7'h59);
    send_char(ASCII_CR);
    wait_rd_valid("abandon_valid");
    @(posedge clock); #1;
    reset = 1'b1; ascii = 7'h4D; ascii_ready = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("abandon_line_valid", 32'(line_valid), 32'd0);
    check("abandon_len", 32'(line_len), 32'd0);
    @(posedge clock); #1;
    ascii_ready = 1'b0;
    check("release_edge_len", 32'(line_len), 32'd1);
    rd_ready = 1'b1;
    push_line(7'h4D, 1'b1);
    send_char(ASCII_CR);
    wait_idle("release_drain");

`ifdef ASCII_LINE_BUFFER_ECHO_EN
    push_line(7'h4B, 1'b1);
    @(posedge clock); #1;
    ascii = 7'h4B; ascii_ready = 1'b1;
    @(posedge clock); #1;
    ascii_ready = 1'b0;
    check("echo_pulse", 32'({echo_valid, echo_char}), 32'({1'b1, 7'h4B}));
    @(posedge clock); #1;
    check("echo_one_cycle", 32'(echo_valid), 32'd0);
    @(posedge clock); #1;
    ascii = ASCII_CR; ascii_ready = 1'b1;
    @(posedge clock); #1;
    ascii_ready = 1'b0;
    check("echo_cr_none", 32'(echo_valid), 32'd0);
    wait_idle("echo_drain");
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
